reg_file_mp: RTL and testbench

Parametrised multi-port integer register file for the next core generation, replacing the fixed 2R/1W, 16×32 file.
- N read ports and M write ports.
- Hardwired zero register.
- Configurable write-to-read forwarding.
- Per-register pending-write scoreboard, so the decoder can detect RAW hazards on destinations still in flight.
- Sits between decoder (read addresses, reservations) and executor/writeback (write ports, read data).

---
 rtl/rv_reg_pkg.sv | 11 +
 rtl/reg_file_mp_if.sv | 34 +++
 rtl/reg_scoreboard.sv | 51 +++++
 rtl/reg_file_mp.sv | 81 ++++++++
 tb/tb_reg_file_mp.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/rv_reg_pkg.sv
// Shared register-file constants and types used by the decoder, the register file and its scoreboard.
package rv_reg_pkg;

  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bundle of all decoder/writeback-facing signals of the multi-port register file.
interface reg_file_mp_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1
);
  localparam int AW = $clog2(NUM_REGS);

  // wr_en and rsv_en are plain qualifiers without back-pressure: every cycle they are
  // high is consumed at the next rising clock edge. Reads have no handshake and are
  // combinational, always valid for the address currently presented.
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*AW-1:0]     wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     rsv_en;
  logic [AW-1:0]            rsv_addr;
  logic [NUM_REGS-1:0]      busy_vec;
  logic                     x0_wr_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_vec, x0_wr_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_vec, x0_wr_err
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus the sticky register-0 access error.
module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int NUM_WR   = 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_WR-1:0]    wr_en_i,
  input  logic [NUM_WR*AW-1:0] wr_addr_i,
  input  logic                 rsv_en_i,
  input  logic [AW-1:0]        rsv_addr_i,
  output logic [NUM_REGS-1:0]  busy_vec_o,
  output logic                 x0_wr_err_o
);
  import rv_reg_pkg::*;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                err_q, err_d;

  // Writes clear first, then a reservation sets, so a same-cycle reserve wins.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en_i[j]) begin
        if (wr_addr_i[j*AW +: AW] == '0) err_d = 1'b1;
        else                             busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_en_i) begin
      if (rsv_addr_i == '0) err_d = 1'b1;
      else                  busy_d[rsv_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_vec_o  = busy_q;
  assign x0_wr_err_o = err_q;

endmodule

// File: rtl/reg_file_mp.sv
// N-read / M-write integer register file with hardwired x0 and a pending-write scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching reads.
module reg_file_mp #(
  parameter int DATA_W   = rv_reg_pkg::DATA_W,
  parameter int NUM_REGS = rv_reg_pkg::NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1
) (
  input  logic          clock,
  input  logic          reset,
  reg_file_mp_if.slave  bus
);
  import rv_reg_pkg::*;

  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [DATA_W-1:0]        regs_d [NUM_REGS];
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;
  logic [NUM_REGS-1:0]      busy_vec;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .AW       (AW)
  ) u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .wr_en_i     (bus.wr_en),
    .wr_addr_i   (bus.wr_addr),
    .rsv_en_i    (bus.rsv_en),
    .rsv_addr_i  (bus.rsv_addr),
    .busy_vec_o  (busy_vec),
    .x0_wr_err_o (bus.x0_wr_err)
  );

  // Ascending port order lets the highest-indexed writer of an address win.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] != '0))
        regs_d[bus.wr_addr[j*AW +: AW]] = bus.wr_data[j*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data_c[i*DATA_W +: DATA_W] = regs_q[bus.rd_addr[i*AW +: AW]];
      rd_busy_c[i]                  = busy_vec[bus.rd_addr[i*AW +: AW]];
`ifdef REG_FILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == bus.rd_addr[i*AW +: AW])) begin
          rd_data_c[i*DATA_W +: DATA_W] = bus.wr_data[j*DATA_W +: DATA_W];
          rd_busy_c[i]                  = 1'b0;
        end
      end
`endif
      // x0 overrides everything, including a (rejected) forwarded write to it.
      if (bus.rd_addr[i*AW +: AW] == '0) begin
        rd_data_c[i*DATA_W +: DATA_W] = '0;
        rd_busy_c[i]                  = 1'b0;
      end
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_busy  = rd_busy_c;
  assign bus.busy_vec = busy_vec;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed, table-driven bench for reg_file_mp (2 read ports, 2 write ports, 16 x 32).
module tb_reg_file_mp;
  import rv_reg_pkg::*;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock;
  logic reset;

  reg_file_mp_if #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(2), .NUM_WR(2)) bus ();

  reg_file_mp #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(2), .NUM_WR(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vectors ----------------
  typedef struct {
    string       name;
    logic [1:0]  wr_en;
    logic [3:0]  wa0;
    logic [31:0] wd0;
    logic [3:0]  wa1;
    logic [31:0] wd1;
    logic        rsv_en;
    logic [3:0]  rsv_a;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic        e_bz0;
    logic        e_bz1;
    logic [15:0] e_bv;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  reg_data_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic vec_t mk(string name, logic [1:0] wr_en, logic [3:0] wa0, logic [31:0] wd0,
                              logic [3:0] wa1, logic [31:0] wd1, logic rsv_en, logic [3:0] rsv_a,
                              logic [3:0] ra0, logic [3:0] ra1, logic [31:0] e_rd0, logic [31:0] e_rd1,
                              logic e_bz0, logic e_bz1, logic [15:0] e_bv, logic e_err);
    vec_t v;
    v.name = name; v.wr_en = wr_en; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.rsv_en = rsv_en; v.rsv_a = rsv_a; v.ra0 = ra0; v.ra1 = ra1;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_bz0 = e_bz0; v.e_bz1 = e_bz1; v.e_bv = e_bv; v.e_err = e_err;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.rd_addr  = '0;
  endtask

  task automatic drive(input vec_t v);
    bus.wr_en    = v.wr_en;
    bus.wr_addr  = {v.wa1, v.wa0};
    bus.wr_data  = {v.wd1, v.wd0};
    bus.rsv_en   = v.rsv_en;
    bus.rsv_addr = v.rsv_a;
    bus.rd_addr  = {v.ra1, v.ra0};
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic check_vec(input vec_t v);
    check({v.name, ".rd0"},  bus.rd_data[31:0],  v.e_rd0);
    check({v.name, ".rd1"},  bus.rd_data[63:32], v.e_rd1);
    check({v.name, ".bz0"},  {31'd0, bus.rd_busy[0]}, {31'd0, v.e_bz0});
    check({v.name, ".bz1"},  {31'd0, bus.rd_busy[1]}, {31'd0, v.e_bz1});
    check({v.name, ".bv"},   {16'd0, bus.busy_vec},   {16'd0, v.e_bv});
    check({v.name, ".err"},  {31'd0, bus.x0_wr_err},  {31'd0, v.e_err});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    //                name            wr_en  wa0 wd0            wa1 wd1      rsv   ra   ra0 ra1  e_rd0                           e_rd1         bz0         bz1  bv       err
    vecs.push_back(mk("reset_read",   2'b00, 0, 32'h0,         0, 32'h0,   1'b0, 0,   5,  0,   32'h0,                          32'h0,        0,          0,   16'h0,   0));
    vecs.push_back(mk("wr_x3",        2'b01, 3, 32'hDEADBEEF,  0, 32'h0,   1'b0, 0,   3,  0,   BYP ? 32'hDEADBEEF : 32'h0,     32'h0,        0,          0,   16'h0,   0));
    vecs.push_back(mk("rd_x3",        2'b00, 0, 32'h0,         0, 32'h0,   1'b0, 0,   3,  5,   32'hDEADBEEF,                   32'h0,        0,          0,   16'h0,   0));
    vecs.push_back(mk("wr_x0",        2'b01, 0, 32'h7,         0, 32'h0,   1'b0, 0,   0,  3,   32'h0,                          32'hDEADBEEF, 0,          0,   16'h0,   0));
    vecs.push_back(mk("x0_err",       2'b00, 0, 32'h0,         0, 32'h0,   1'b0, 0,   0,  3,   32'h0,                          32'hDEADBEEF, 0,          0,   16'h0,   1));
    vecs.push_back(mk("conflict",     2'b11, 4, 32'h11,        4, 32'h22,  1'b0, 0,   4,  3,   BYP ? 32'h22 : 32'h0,           32'hDEADBEEF, 0,          0,   16'h0,   1));
    vecs.push_back(mk("conflict_rd",  2'b00, 0, 32'h0,         0, 32'h0,   1'b0, 0,   4,  3,   32'h22,                         32'hDEADBEEF, 0,          0,   16'h0,   1));
    vecs.push_back(mk("rsv_x6",       2'b00, 0, 32'h0,         0, 32'h0,   1'b1, 6,   6,  4,   32'h0,                          32'h22,       0,          0,   16'h0,   1));
    vecs.push_back(mk("busy_x6",      2'b00, 0, 32'h0,         0, 32'h0,   1'b0, 0,   6,  0,   32'h0,                          32'h0,        1,          0,   16'h0040, 1));
    vecs.push_back(mk("wr_x6",        2'b10, 0, 32'h0,         6, 32'h55,  1'b0, 0,   6,  6,   BYP ? 32'h55 : 32'h0,           BYP ? 32'h55 : 32'h0, !BYP, !BYP, 16'h0040, 1));
    vecs.push_back(mk("x6_clear",     2'b00, 0, 32'h0,         0, 32'h0,   1'b0, 0,   6,  4,   32'h55,                         32'h22,       0,          0,   16'h0,   1));
    vecs.push_back(mk("rsv_wr_x6",    2'b01, 6, 32'h66,        0, 32'h0,   1'b1, 6,   6,  4,   BYP ? 32'h66 : 32'h55,          32'h22,       0,          0,   16'h0,   1));
    vecs.push_back(mk("x6_busy",      2'b00, 0, 32'h0,         0, 32'h0,   1'b0, 0,   6,  4,   32'h66,                         32'h22,       1,          0,   16'h0040, 1));
    vecs.push_back(mk("rsv_again",    2'b00, 0, 32'h0,         0, 32'h0,   1'b1, 6,   6,  6,   32'h66,                         32'h66,       1,          1,   16'h0040, 1));
    vecs.push_back(mk("still_busy",   2'b00, 0, 32'h0,         0, 32'h0,   1'b0, 0,   6,  3,   32'h66,                         32'hDEADBEEF, 1,          0,   16'h0040, 1));
    vecs.push_back(mk("wr_x6b",       2'b01, 6, 32'h77,        0, 32'h0,   1'b0, 0,   6,  0,   BYP ? 32'h77 : 32'h66,          32'h0,        !BYP,       0,   16'h0040, 1));
    vecs.push_back(mk("x6_final",     2'b00, 0, 32'h0,         0, 32'h0,   1'b0, 0,   6,  3,   32'h77,                         32'hDEADBEEF, 0,          0,   16'h0,   1));

    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    foreach (vecs[k]) begin
      drive(vecs[k]);
      #3;
      check_vec(vecs[k]);
      tick();
    end

    // Forwarding of a same-cycle write to x9 on both read ports.
    idle();
    bus.wr_en   = 2'b01;
    bus.wr_addr = {4'd0, 4'd9};
    bus.wr_data = {32'h0, 32'h0000A5A5};
    bus.rd_addr = {4'd9, 4'd9};
    #3;
    check("fwd_x9.rd0", bus.rd_data[31:0],  BYP ? 32'h0000A5A5 : 32'h0);
    check("fwd_x9.rd1", bus.rd_data[63:32], BYP ? 32'h0000A5A5 : 32'h0);
    check("fwd_x9.bz",  {30'd0, bus.rd_busy}, 32'h0);
    exp_q.push_back(32'h0000A5A5);
    tick();
    idle();
    bus.rd_addr = {4'd0, 4'd9};
    #3;
    check("fwd_x9.next", bus.rd_data[31:0], exp_q.pop_front());

    // Reset in the middle of outstanding reservations and writes.
    tick();
    idle();
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 4'd2;
    bus.wr_en    = 2'b01;
    bus.wr_addr  = {4'd0, 4'd7};
    bus.wr_data  = {32'h0, 32'h1};
    tick();
    idle();
    bus.rd_addr = {4'd0, 4'd7};
    #1;
    check("pre_rst.bv",  {16'd0, bus.busy_vec}, 32'h0004);
    check("pre_rst.x7",  bus.rd_data[31:0], 32'h1);
    check("pre_rst.err", {31'd0, bus.x0_wr_err}, 32'h1);
    reset        = 1'b1;
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 4'd7;
    bus.wr_en    = 2'b11;
    bus.wr_addr  = {4'd4, 4'd3};
    bus.wr_data  = {32'h44, 32'h9};
    tick();
    reset = 1'b0;
    idle();
    #1;
    check("post_rst.bv",  {16'd0, bus.busy_vec}, 32'h0);
    check("post_rst.err", {31'd0, bus.x0_wr_err}, 32'h0);
    for (int r = 1; r < 16; r += 2) begin
      bus.rd_addr = {4'((r + 1) % 16), 4'(r)};
      #1;
      check($sformatf("post_rst.x%0d", r),            bus.rd_data[31:0],  32'h0);
      check($sformatf("post_rst.x%0d", (r + 1) % 16), bus.rd_data[63:32], 32'h0);
      check($sformatf("post_rst.bz%0d", r),           {30'd0, bus.rd_busy}, 32'h0);
    end

    // Reserving x0 only raises the sticky error.
    tick();
    idle();
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 4'd0;
    #3;
    check("rsv_x0.err_before", {31'd0, bus.x0_wr_err}, 32'h0);
    tick();
    idle();
    #3;
    check("rsv_x0.err_after", {31'd0, bus.x0_wr_err}, 32'h1);
    check("rsv_x0.bv",        {16'd0, bus.busy_vec}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
